// File: rtl/stopwatch_if.sv
// Front-panel control strobes, preload value and count/status outputs of the stopwatch core.
// master drives the strobes and the preload value; slave is the core.
interface stopwatch_if;
    logic        start_stop;
    logic        clear;
    logic [31:0] test_value;
    logic        latch_test_value;
    logic [31:0] digits;
    logic        running;
    logic        tick;
    logic        rollover;

    modport master (
        output start_stop, clear, test_value, latch_test_value,
        input  digits, running, tick, rollover
    );

    modport slave (
        input  start_stop, clear, test_value, latch_test_value,
        output digits, running, tick, rollover
    );
endinterface

// File: rtl/stopwatch_core.sv
// BCD HH:MM:SS.cc stopwatch counting one step per CLK_HZ/TICK_HZ clocks while running.
// All outputs registered; load/clear/start_stop visible one cycle after the strobe.
// No backpressure: every strobe is acted on in the cycle it is sampled.
module stopwatch_core #(
    parameter int CLK_HZ  = 100_000_000,
    parameter int TICK_HZ = 100
) (
    input  logic clk,
    input  logic resetn,
    stopwatch_if.slave sw
);
    localparam int DIV = CLK_HZ / TICK_HZ;
    localparam int PW  = (DIV > 2) ? $clog2(DIV) : 1;

    // Per-digit maximum, same nibble packing as digits: H1 H0 M1 M0 S1 S0 C1 C0.
    localparam logic [31:0] LIM = 32'h9959_5999;

    logic [PW-1:0] presc_q;
    logic [31:0]   digits_q;
    logic          running_q;
    logic          tick_q;
    logic          rollover_q;

    logic [31:0]   inc_val;
    logic [31:0]   clamp_val;
    logic          inc_wrap;
    logic          term;

    assign term = running_q && (presc_q == PW'(DIV - 1));

    always_comb begin
        logic carry;
        carry     = 1'b1;
        inc_val   = digits_q;
        clamp_val = '0;
        for (int i = 0; i < 8; i++) begin
            if (carry) begin
                if (digits_q[i*4 +: 4] >= LIM[i*4 +: 4]) begin
                    inc_val[i*4 +: 4] = 4'd0;
                end else begin
                    inc_val[i*4 +: 4] = digits_q[i*4 +: 4] + 4'd1;
                    carry             = 1'b0;
                end
            end
            clamp_val[i*4 +: 4] = (sw.test_value[i*4 +: 4] > LIM[i*4 +: 4]) ?
                                  LIM[i*4 +: 4] : sw.test_value[i*4 +: 4];
        end
        inc_wrap = carry;
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            presc_q    <= '0;
            digits_q   <= '0;
            running_q  <= 1'b0;
            tick_q     <= 1'b0;
            rollover_q <= 1'b0;
        end else begin
            tick_q     <= 1'b0;
            rollover_q <= 1'b0;
            // A terminal count coinciding with load or clear is dropped.
            if (sw.latch_test_value) begin
                digits_q <= clamp_val;
                presc_q  <= '0;
            end else if (sw.clear) begin
                digits_q <= '0;
                presc_q  <= '0;
            end else if (term) begin
                digits_q   <= inc_val;
                presc_q    <= '0;
                tick_q     <= 1'b1;
                rollover_q <= inc_wrap;
            end else if (running_q) begin
                presc_q <= presc_q + PW'(1);
            end

            if (sw.clear) begin
                running_q <= 1'b0;
            end else if (sw.start_stop) begin
                running_q <= ~running_q;
            end
        end
    end

    assign sw.digits   = digits_q;
    assign sw.running  = running_q;
    assign sw.tick     = tick_q;
    assign sw.rollover = rollover_q;
endmodule

// File: tb/tb_stopwatch_core.sv
// Directed vector bench for stopwatch_core with DIV = 10.
module tb_stopwatch_core;
    logic clk = 1'b0;
    logic resetn = 1'b0;

    stopwatch_if sw ();

    stopwatch_core #(.CLK_HZ(1000), .TICK_HZ(100)) dut (
        .clk    (clk),
        .resetn (resetn),
        .sw     (sw.slave)
    );

    always #5 clk = ~clk;

    int tick_total = 0;
    int roll_total = 0;
    always @(negedge clk) begin
        if (sw.tick)     tick_total++;
        if (sw.rollover) roll_total++;
    end

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        ss;
        logic        clr;
        logic        ld;
        logic [31:0] tv;
        int          w;
        logic [31:0] d;
        logic        r;
        int          nt;
        int          nr;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Strobe inputs for one edge, then w further edges; check state and strobe counts.
    task automatic run_vec(input vec_t v, input string tag);
        int t0, r0;
        t0 = tick_total;
        r0 = roll_total;
        sw.start_stop       = v.ss;
        sw.clear            = v.clr;
        sw.latch_test_value = v.ld;
        sw.test_value       = v.tv;
        @(negedge clk); #1;
        sw.start_stop       = 1'b0;
        sw.clear            = 1'b0;
        sw.latch_test_value = 1'b0;
        sw.test_value       = '0;
        repeat (v.w) begin
            @(negedge clk); #1;
        end
        chk({tag, " digits"},   sw.digits,          v.d);
        chk({tag, " running"},  32'(sw.running),    32'(v.r));
        chk({tag, " ticks"},    32'(tick_total - t0), 32'(v.nt));
        chk({tag, " rollover"}, 32'(roll_total - r0), 32'(v.nr));
    endtask

    initial begin
        sw.start_stop       = 1'b0;
        sw.clear            = 1'b0;
        sw.latch_test_value = 1'b0;
        sw.test_value       = '0;

        //            ss    clr   ld    test_value     w   digits         run  nt nr
        vecs.push_back('{1'b1, 1'b0, 1'b0, 32'h0,         100, 32'h0000_0010, 1'b1, 10, 0});
        vecs.push_back('{1'b1, 1'b0, 1'b0, 32'h0,         0,   32'h0000_0010, 1'b0, 0,  0});
        vecs.push_back('{1'b0, 1'b1, 1'b0, 32'h0,         0,   32'h0000_0000, 1'b0, 0,  0});
        vecs.push_back('{1'b0, 1'b0, 1'b1, 32'h9959_5998, 3,   32'h9959_5998, 1'b0, 0,  0});
        vecs.push_back('{1'b1, 1'b0, 1'b0, 32'h0,         10,  32'h9959_5999, 1'b1, 1,  0});
        vecs.push_back('{1'b0, 1'b0, 1'b0, 32'h0,         9,   32'h0000_0000, 1'b1, 1,  1});
        vecs.push_back('{1'b0, 1'b0, 1'b0, 32'h0,         9,   32'h0000_0001, 1'b1, 1,  0});
        vecs.push_back('{1'b1, 1'b0, 1'b0, 32'h0,         0,   32'h0000_0001, 1'b0, 0,  0});
        vecs.push_back('{1'b0, 1'b0, 1'b1, 32'hFF6A_7BCD, 0,   32'h9959_5999, 1'b0, 0,  0});
        vecs.push_back('{1'b1, 1'b0, 1'b0, 32'h0,         8,   32'h9959_5999, 1'b1, 0,  0});
        vecs.push_back('{1'b0, 1'b0, 1'b0, 32'h0,         0,   32'h9959_5999, 1'b1, 0,  0});
        vecs.push_back('{1'b0, 1'b0, 1'b1, 32'h1234_5678, 0,   32'h1234_5678, 1'b1, 0,  0});
        vecs.push_back('{1'b0, 1'b0, 1'b0, 32'h0,         9,   32'h1234_5679, 1'b1, 1,  0});
        vecs.push_back('{1'b0, 1'b1, 1'b0, 32'h0,         0,   32'h0000_0000, 1'b0, 0,  0});
        vecs.push_back('{1'b1, 1'b0, 1'b0, 32'h0,         24,  32'h0000_0002, 1'b1, 2,  0});
        vecs.push_back('{1'b1, 1'b0, 1'b0, 32'h0,         0,   32'h0000_0002, 1'b0, 0,  0});
        vecs.push_back('{1'b0, 1'b0, 1'b0, 32'h0,         49,  32'h0000_0002, 1'b0, 0,  0});
        vecs.push_back('{1'b1, 1'b0, 1'b0, 32'h0,         4,   32'h0000_0002, 1'b1, 0,  0});
        vecs.push_back('{1'b0, 1'b0, 1'b0, 32'h0,         0,   32'h0000_0003, 1'b1, 1,  0});
        vecs.push_back('{1'b1, 1'b1, 1'b0, 32'h0,         0,   32'h0000_0000, 1'b0, 0,  0});
        vecs.push_back('{1'b0, 1'b1, 1'b1, 32'h0000_1234, 0,   32'h0000_1234, 1'b0, 0,  0});
        vecs.push_back('{1'b1, 1'b0, 1'b0, 32'h0,         9,   32'h0000_1234, 1'b1, 0,  0});
        vecs.push_back('{1'b1, 1'b0, 1'b0, 32'h0,         0,   32'h0000_1235, 1'b0, 1,  0});
        vecs.push_back('{1'b1, 1'b0, 1'b0, 32'h0,         0,   32'h0000_1235, 1'b1, 0,  0});
        vecs.push_back('{1'b1, 1'b0, 1'b0, 32'h0,         0,   32'h0000_1235, 1'b0, 0,  0});

        repeat (3) @(negedge clk);
        #1;
        chk("reset digits",   sw.digits,          32'h0);
        chk("reset running",  32'(sw.running),    32'h0);
        chk("reset tick",     32'(sw.tick),       32'h0);
        chk("reset rollover", 32'(sw.rollover),   32'h0);
        resetn = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            run_vec(vecs[i], $sformatf("v%0d", i));
        end

        // Mid-count reset: everything lost, nothing counts until restarted.
        run_vec('{1'b0, 1'b1, 1'b0, 32'h0, 0,  32'h0000_0000, 1'b0, 0, 0}, "rst_pre_clear");
        run_vec('{1'b1, 1'b0, 1'b0, 32'h0, 12, 32'h0000_0001, 1'b1, 1, 0}, "rst_pre_run");
        resetn = 1'b0;
        @(negedge clk); #1;
        chk("midrst digits",   sw.digits,        32'h0);
        chk("midrst running",  32'(sw.running),  32'h0);
        chk("midrst tick",     32'(sw.tick),     32'h0);
        chk("midrst rollover", 32'(sw.rollover), 32'h0);
        resetn = 1'b1;
        run_vec('{1'b0, 1'b0, 1'b0, 32'h0, 29, 32'h0000_0000, 1'b0, 0, 0}, "rst_idle");
        run_vec('{1'b1, 1'b0, 1'b0, 32'h0, 10, 32'h0000_0001, 1'b1, 1, 0}, "rst_restart");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/stopwatch_core.md
# stopwatch_core

Timekeeping engine of the Nexys stopwatch. Counts elapsed time as eight packed BCD digits (HH:MM:SS.cc) from a clock-derived 1/100 s tick, under start/stop and clear pulses from the front-panel debouncers. Sits directly downstream of the AXI-Lite configuration block, consuming its `test_value`/`latch_test_value` pair to preload the count. Its digit output feeds the seven-segment display driver.

## Interface
- `CLK_HZ`, 100_000_000, input clock frequency in Hz
- `TICK_HZ`, 100, count rate; one tick is one hundredth of a second; `CLK_HZ/TICK_HZ` must be an integer ≥ 2
- `clk`  in  1  system clock
- `resetn`  in  1  reset; one clock, reset is synchronous and active-low
- `start_stop`  in  1  single-cycle pulse; toggles running/stopped
- `clear`  in  1  single-cycle pulse; zeroes count and stops
- `test_value`  in  32  preload value, packed BCD {H1,H0,M1,M0,S1,S0,C1,C0}, H1 in [31:28]
- `latch_test_value`  in  1  single-cycle strobe; load `test_value` into the count
- `digits`  out  32  current count, same packing as `test_value`
- `running`  out  1  1 = counting
- `tick`  out  1  single-cycle strobe, high the cycle after `digits` advanced
- `rollover`  out  1  single-cycle strobe, high the cycle after a wrap from 99:59:59.99 to 00:00:00.00

## Operation
- Prescaler counts 0..DIV-1, where DIV = CLK_HZ/TICK_HZ. It advances only while `running`=1. At DIV-1 it returns to 0 and the count increments once.
- While stopped, the prescaler holds its value. It is zeroed by reset, `clear` and load.
- Increment is a BCD ripple:
  - C0 0-9, carrying into C1 0-9;
  - then S0 0-9 and S1 0-5;
  - then M0 0-9 and M1 0-5;
  - then H0 0-9 and H1 0-9.
- Incrementing past 99:59:59.99 yields all zeros and pulses `rollover`. Counting continues after the wrap.
- Load (`latch_test_value`=1) clamps `test_value` per field before writing `digits`:
  - any ones or hundredths nibble, and H1, above 9 becomes 9;
  - M1 or S1 above 5 becomes 5.
- Load does not change `running`.
- `clear` sets `digits`=0 and `running`=0.
- `start_stop` inverts `running`.
- Priority within one cycle: `resetn`=0 > load > `clear` > increment. `start_stop` is evaluated independently, except when `clear` is also high, in which case `running`=0.
- A prescaler terminal count that coincides with a load or clear is discarded; no `tick` is produced.
- An increment in the same cycle as `start_stop` uses the pre-toggle `running` value, so a stop pulse on the terminal-count cycle still increments.

## Timing
- Reset values: `digits`=0, `running`=0, `tick`=0, `rollover`=0, prescaler=0.
- All outputs are registered.
- `digits` reflects a load or clear on the cycle after the strobe.
- `running` changes on the cycle after `start_stop`.
- From start with prescaler=0, the first increment appears DIV cycles after the `start_stop` pulse. Further increments follow every DIV cycles.
- `tick` and `rollover` are high for exactly one cycle, coincident with the updated `digits`.
- A reset asserted mid-count returns every output to its reset value on the next edge. Count, running state and prescaler are all lost.
- No handshake on inputs: every pulse is acted on in the cycle it is sampled. Back-to-back `start_stop` pulses toggle twice.

## Test plan
Bench parameters: CLK_HZ=1000, TICK_HZ=100, giving DIV=10.

1. Reset, pulse `start_stop`, run 100 cycles → `digits`=0x00000010, `running`=1, exactly 10 `tick` pulses.
2. Load 0x99595998, start, run 20 cycles → `digits` reads 0x99595999, then 0x00000000 with one `rollover` pulse, then keeps counting.
3. Load 0xFF6A7BCD → `digits`=0x99595999 and `running` unchanged. Load 0x12345678 while running → `digits`=0x12345678 the next cycle, counting continues, the coincident terminal count is dropped.
4. Start, pulse `start_stop` after 25 cycles → `digits`=0x00000002 and stays frozen for 50 cycles. Restart → next increment 5 cycles later, because the prescaler resumed from 5.
5. Pulse `clear` and `start_stop` in the same cycle while running → `digits`=0, `running`=0. Pulse `clear` together with `latch_test_value`=0x00001234 → `digits`=0x00001234.
6. Pulse `resetn` low for one cycle mid-count → every output is 0 the following cycle, and no further ticks occur until `start_stop` is pulsed.
